// File: rtl/cycle_trace.sv
// Negative-cycle tracer: scans the adjacency RAM for relaxable edges and emits each cycle in predecessor order.
// Optional macro CYCLE_TRACE_WEIGHT_EN adds out_weight (total edge weight of the reported cycle).
module cycle_trace #(
    parameter int NODES      = 16,
    parameter int PRED_W     = 4,
    parameter int WEIGHT_W   = 16,
    parameter int MAX_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        cycle_reset,
    input  logic                        start,
    output logic [PRED_W-1:0]           vert_addr_a,
    output logic [PRED_W-1:0]           vert_addr_b,
    input  logic [PRED_W+WEIGHT_W-1:0]  vert_q_a,
    input  logic [PRED_W+WEIGHT_W-1:0]  vert_q_b,
    output logic [PRED_W-1:0]           adj_row_addr,
    output logic [PRED_W-1:0]           adj_col_addr,
    input  logic [WEIGHT_W-1:0]         adj_q,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PRED_W-1:0]           out_vertex,
    output logic                        out_last,
    output logic [7:0]                  cycle_count,
`ifdef CYCLE_TRACE_WEIGHT_EN
    output logic signed [WEIGHT_W+PRED_W-1:0] out_weight,
`endif
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {IDLE, FETCH, CHECK, WALK, TRACE, EMIT, DONE} state_t;

    localparam logic [PRED_W-1:0] LAST_IDX  = PRED_W'(NODES - 1);
    localparam logic [PRED_W:0]   WALK_INIT = (PRED_W + 1)'(NODES);

    state_t state, state_nxt;

    logic [PRED_W-1:0]   i, j, v, s, c, nxt_c;
    logic [PRED_W-1:0]   i_step, j_step;
    logic [PRED_W:0]     walk_cnt;
    logic [PRED_W-1:0]   beat_cnt;
    logic [1:0]          phase;
    logic [PRED_W-1:0]   pred_a;
    logic [WEIGHT_W-1:0] svw, dvw;
    logic signed [WEIGHT_W:0] lhs, rhs;
    logic                viol, last_edge, max_hit, trace_end;
    logic                unused_pred_b;

    assign pred_a        = vert_q_a[PRED_W+WEIGHT_W-1:WEIGHT_W];
    assign svw           = vert_q_a[WEIGHT_W-1:0];
    assign dvw           = vert_q_b[WEIGHT_W-1:0];
    assign unused_pred_b = ^vert_q_b[PRED_W+WEIGHT_W-1:WEIGHT_W];

    // One extra bit of headroom so svw+e can never wrap.
    assign lhs  = $signed({svw[WEIGHT_W-1], svw}) + $signed({adj_q[WEIGHT_W-1], adj_q});
    assign rhs  = $signed({dvw[WEIGHT_W-1], dvw});
    assign viol = (adj_q != '0) && (i != j) && (lhs < rhs);

    assign last_edge = (i == LAST_IDX) && (j == LAST_IDX);
    assign i_step    = (j == LAST_IDX) ? i + 1'b1 : i;
    assign j_step    = (j == LAST_IDX) ? '0 : j + 1'b1;
    assign max_hit   = (int'(cycle_count) + 1 == MAX_CYCLES);

`ifdef CYCLE_TRACE_WEIGHT_EN
    // Two extra phases: address edge (pred(c),c), then accumulate its weight.
    assign trace_end = (phase == 2'd3);
`else
    assign trace_end = (phase == 2'd1);
`endif

    assign out_valid  = (state == EMIT);
    assign out_vertex = c;
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        if (cycle_reset) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        vert_addr_a  = '0;
        vert_addr_b  = '0;
        adj_row_addr = '0;
        adj_col_addr = '0;
        case (state)
            IDLE, DONE: if (start) state_nxt = FETCH;
            FETCH: begin
                vert_addr_a  = i;
                vert_addr_b  = j;
                adj_row_addr = i;
                adj_col_addr = j;
                state_nxt    = CHECK;
            end
            CHECK: begin
                if (viol)           state_nxt = WALK;
                else if (last_edge) state_nxt = DONE;
                else                state_nxt = FETCH;
            end
            WALK: begin
                vert_addr_a = v;
                if (phase[0] && walk_cnt == (PRED_W + 1)'(1)) state_nxt = TRACE;
            end
            TRACE: begin
                vert_addr_a = c;
`ifdef CYCLE_TRACE_WEIGHT_EN
                adj_row_addr = nxt_c;
                adj_col_addr = c;
`endif
                if (trace_end) state_nxt = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (!out_last)                state_nxt = TRACE;
                    else if (max_hit || last_edge) state_nxt = DONE;
                    else                          state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cycle_reset) begin
            i           <= '0;
            j           <= '0;
            v           <= '0;
            s           <= '0;
            c           <= '0;
            nxt_c       <= '0;
            walk_cnt    <= '0;
            beat_cnt    <= '0;
            phase       <= '0;
            cycle_count <= '0;
            out_last    <= 1'b0;
`ifdef CYCLE_TRACE_WEIGHT_EN
            out_weight  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        i           <= '0;
                        j           <= '0;
                        cycle_count <= '0;
                        out_last    <= 1'b0;
                    end
                end
                CHECK: begin
                    if (viol) begin
                        v        <= j;
                        walk_cnt <= WALK_INIT;
                        phase    <= '0;
                    end else begin
                        i <= i_step;
                        j <= j_step;
                    end
                end
                WALK: begin
                    phase <= {1'b0, ~phase[0]};
                    if (phase[0]) begin
                        v        <= pred_a;
                        walk_cnt <= walk_cnt - 1'b1;
                        if (walk_cnt == (PRED_W + 1)'(1)) begin
                            s        <= pred_a;
                            c        <= pred_a;
                            beat_cnt <= '0;
`ifdef CYCLE_TRACE_WEIGHT_EN
                            out_weight <= '0;
`endif
                        end
                    end
                end
                TRACE: begin
                    phase <= phase + 1'b1;
                    if (phase == 2'd1) begin
                        nxt_c    <= pred_a;
                        out_last <= (pred_a == s) || (beat_cnt == LAST_IDX);
                    end
`ifdef CYCLE_TRACE_WEIGHT_EN
                    if (phase == 2'd3)
                        out_weight <= out_weight + {{PRED_W{adj_q[WEIGHT_W-1]}}, adj_q};
`endif
                end
                EMIT: begin
                    phase <= '0;
                    if (out_ready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        c        <= nxt_c;
                        if (out_last) begin
                            cycle_count <= cycle_count + 1'b1;
                            out_last    <= 1'b0;
                            i           <= i_step;
                            j           <= j_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cycle_trace.md
CYCLE_TRACE -- requirements
Module: cycle_trace

Interface
REQ-001 Parameter NODES, default 16: number of vertices; vertex indices 0..NODES-1.
REQ-002 Parameter PRED_W, default 4: vertex index width; SHALL satisfy 2**PRED_W >= NODES.
REQ-003 Parameter WEIGHT_W, default 16: signed edge/vertex weight width.
REQ-004 Parameter MAX_CYCLES, default 8: number of reported cycles after which the scan stops.
REQ-005 Ports (name, direction, width, meaning); one clock; reset is synchronous and active-high:
- clk  in  1  sole clock.
- cycle_reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a scan from IDLE.
- vert_addr_a, vert_addr_b  out  PRED_W  vertex RAM ports A/B.
- vert_q_a, vert_q_b  in  PRED_W+WEIGHT_W  {pred[PRED_W-1:0], weight[WEIGHT_W-1:0]}.
- adj_row_addr, adj_col_addr  out  PRED_W  adjacency RAM address.
- adj_q  in  WEIGHT_W  signed edge weight; 0 = no edge.
- out_valid  out  1  cycle-vertex beat valid.
- out_ready  in  1  consumer accepts beat.
- out_vertex  out  PRED_W  vertex index of beat.
- out_last  out  1  final vertex of current cycle.
- cycle_count  out  8  cycles fully emitted this scan.
- busy  out  1  high from start until DONE.
- done  out  1  scan complete; held until cycle_reset or start.

Function
REQ-006 All RAM reads SHALL have one-cycle latency: address in cycle N, q used in cycle N+1.
REQ-007 States: IDLE, FETCH, CHECK, WALK, TRACE, EMIT, DONE.
REQ-008 IDLE: start -> FETCH with i=0, j=0, cycle_count=0, done=0, busy=1.
REQ-009 FETCH: drive vert_addr_a=i, vert_addr_b=j, adj=(i,j); next state CHECK.
REQ-010 CHECK: violation iff adj_q!=0 and i!=j and svw+e < dvw, evaluated in WEIGHT_W+1-bit signed arithmetic (no overflow).
REQ-011 CHECK without violation: advance row-major (j++, wrap j to 0 and i++); after edge (NODES-1,NODES-1) go to DONE; otherwise go to FETCH.
REQ-012 CHECK with violation: v=j, walk counter=NODES, go to WALK.
REQ-013 WALK: v=pred(v) every 2 cycles (address, then read) for NODES steps; final v is latched as anchor s and current vertex c; go to TRACE.
REQ-014 TRACE: read pred(c) (2 cycles); go to EMIT with out_last = (pred(c)==s) or (beats emitted this cycle == NODES-1).
REQ-015 EMIT: out_valid=1, out_vertex=c; out_vertex and out_last SHALL hold stable until out_ready; on out_valid&&out_ready: if out_last, cycle_count++ and resume the scan at the next edge after the violating one (DONE if cycle_count+1==MAX_CYCLES or the edge was last); else c=pred(c), go to TRACE.
REQ-016 Beats SHALL be emitted in predecessor order starting at s: s, pred(s), pred(pred(s)), ...
REQ-017 No duplicate suppression: the same cycle MAY be reported once per violating edge.
REQ-018 DONE: busy=0, done=1, out_valid=0; start SHALL restart a scan (REQ-008).
REQ-019 start SHALL be ignored outside IDLE and DONE.

Reset
REQ-020 cycle_reset in any state, including mid-EMIT, SHALL on the next edge give state=IDLE, out_valid=0, out_last=0, busy=0, done=0, cycle_count=0, all addresses=0; a pending beat is discarded.
REQ-021 cycle_reset SHALL dominate start in the same cycle.

Configuration
REQ-022 Macro CYCLE_TRACE_WEIGHT_EN defined: add port out_weight, out, WEIGHT_W+PRED_W, signed; during TRACE drive adj=(pred(c),c) and accumulate adj_q; out_weight is valid on the out_last beat as the cycle's total weight; the accumulator clears at WALK exit.
REQ-023 Macro undefined: no out_weight port; adjacency RAM is not addressed outside FETCH/CHECK.

Verification
REQ-024 NODES=4; consistent weights, no negative cycle; start -> done after 16 edge checks, cycle_count=0, out_valid never asserted.
REQ-025 Cycle 0->1->2->0 with each edge -1, preds {0:2,1:0,2:1}, all vertex weights 0 -> beats 0,2,1, out_last on 1, cycle_count=1; with the macro, out_weight=-3.
REQ-026 Same as REQ-025 with out_ready low 5 cycles on each beat -> out_vertex/out_last stable while stalled, same beat sequence.
REQ-027 cycle_reset asserted while out_valid=1 -> next cycle out_valid=0, busy=0, cycle_count=0, state IDLE.
REQ-028 MAX_CYCLES=1, two disjoint negative cycles -> exactly one cycle emitted, then done=1.
REQ-029 Edge weights -32768 and vertex weights at +32767 (WEIGHT_W=16) -> comparison correct, no overflow false positive.
